alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Stage directly downstream of the ALU. Captures {opcode, rd, out_data, ovf, condition} per op into a
//  small in-order queue, retires entries to the register-file write port under a valid/ready handshake,
//  keeps the architectural status flags {EQ,NE,GT,LT}, and raises a sticky overflow trap.
//  Also provides a combinational bypass lookup so operand fetch can forward results not yet retired.
// PARAMETERS
//  DEPTH      2   queue entries (power of 2, >=2)
//  XLEN       32  datapath width
//  RA_W       5   register address width
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  in_valid     in   1     ALU result valid this cycle
//  in_ready     out  1     queue can accept (= !full)
//  in_opcode    in   4     ALU opcode of the op
//  in_rd        in   RA_W  destination register
//  in_result    in   XLEN  ALU out_data
//  in_ovf       in   1     ALU overflow flag
//  in_cond      in   4     ALU condition {EQ,NE,GT,LT}
//  in_trap_en   in   1     op traps on overflow (signed ADD/SUB/SLT)
//  rf_valid     out  1     head entry presented
//  rf_ready     in   1     register file accepts head
//  rf_we        out  1     head writes a register (qualified by rf_valid)
//  rf_waddr     out  RA_W  head rd
//  rf_wdata     out  XLEN  head result
//  flags        out  4     architectural {EQ,NE,GT,LT}
//  trap_pending out  1     sticky overflow trap
//  trap_clr     in   1     clears trap_pending
//  fwd_rs       in   RA_W  bypass query register
//  fwd_hit      out  1     queued result exists for fwd_rs
//  fwd_data     out  XLEN  youngest matching queued result
// BEHAVIOUR
//  - Reset (rst_n=0, async): queue empty, rd/wr ptrs=0, flags=4'b0000, trap_pending=0; hence in_ready=1,
//    rf_valid=0, rf_we=0, fwd_hit=0. Reset mid-operation discards all queued entries without writing them.
//  - Push on in_valid&in_ready at posedge; earliest retire the following cycle (latency 1). No input->output combinational path.
//  - in_ready = (count!=DEPTH); depends on registered state only. Push into a full queue cannot occur;
//    push+pop in the same cycle when full is not allowed (in_ready is 0).
//  - Push+pop in the same cycle at 0<count<DEPTH: count unchanged, both pointers advance, wrapping mod DEPTH.
//  - Each entry stores wen = (rd!=0) & !(ovf & trap_en); this is computed at push.
//  - rf_valid = (count!=0) & !trap_pending; pop on rf_valid&rf_ready. rf_we = rf_valid & head.wen.
//  - On pop of an entry with ovf&trap_en: trap_pending<=1 and no write. All later entries are flushed
//    (count<=0) the next cycle. While trap_pending=1, pushes are accepted and dropped, and count stays 0.
//  - trap_clr clears trap_pending next edge. trap_clr and a new trap in the same cycle: the set wins.
//  - flags <= head.cond on pop when head.opcode==OP_SUB (4'h2) and the entry is not trapping. Other ops leave flags unchanged.
//  - Bypass: scan valid entries with wen=1 and rd==fwd_rs, oldest to youngest. The youngest match drives fwd_data.
//    fwd_rs==0 gives fwd_hit=0. While trap_pending=1, fwd_hit=0.
//  - Opcodes MULT/DIV/MULTU/DIVU (4'hA-4'hD) are queued and retired like any other op. This stage does not inspect in_result.
// STRUCTURE
//  - Shared package alu_pkg: 4-bit OP_* constants (OUT=0 ADD=1 SUB=2 AND=3 OR=4 NOR=5 XOR=6 SLL=7 SRL=8 SRA=9
//    MULT=A DIV=B MULTU=C DIVU=D SLT=E SLTU=F), COND_EQ/NE/GT/LT bit indices, entry struct {op,rd,res,ovf,cond,trap,wen}.
//  - One sub-module, wb_queue: parameterized DEPTH FIFO that exposes all entries for the bypass scan.
//    Flag, trap and retire logic live in the top module.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, rf_valid=0, flags=0, trap_pending=0.
//    Release reset -> first push retires 1 cycle later.
//  2 Push SUB rd=3 res=0 cond=1000, then ADD rd=4 res=7, with rf_ready=1 -> rf_we with (3,0), then (4,7)
//    on consecutive cycles. flags=1000 after the first pop and unchanged after the second.
//  3 Backpressure: rf_ready=0, push 2 ops -> in_ready=0 after the second push. A 3rd in_valid is not accepted.
//    Raise rf_ready -> in-order drain, and in_ready returns to 1 after the first pop.
//  4 rd=0 push with res=0xDEAD -> rf_valid=1, rf_we=0. fwd_rs=0 -> fwd_hit=0.
//  5 ADD ovf=1 trap_en=1 rd=5, followed by OR rd=6 -> no write to 5 or 6, and trap_pending=1.
//    Pushes while pending are dropped. trap_clr -> trap_pending=0, and the next push retires normally.
//  6 Bypass: queue (7,0x11) then (7,0x22), fwd_rs=7 -> fwd_hit=1, fwd_data=0x22.
//    Same test with ovf=1 trap_en=1 on the first entry -> fwd_data=0x22.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback stage: opcode constants, condition-flag bit
// positions, datapath widths and the queue entry record.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_OUT   = 4'h0;
  localparam opcode_t OP_ADD   = 4'h1;
  localparam opcode_t OP_SUB   = 4'h2;
  localparam opcode_t OP_AND   = 4'h3;
  localparam opcode_t OP_OR    = 4'h4;
  localparam opcode_t OP_NOR   = 4'h5;
  localparam opcode_t OP_XOR   = 4'h6;
  localparam opcode_t OP_SLL   = 4'h7;
  localparam opcode_t OP_SRL   = 4'h8;
  localparam opcode_t OP_SRA   = 4'h9;
  localparam opcode_t OP_MULT  = 4'hA;
  localparam opcode_t OP_DIV   = 4'hB;
  localparam opcode_t OP_MULTU = 4'hC;
  localparam opcode_t OP_DIVU  = 4'hD;
  localparam opcode_t OP_SLT   = 4'hE;
  localparam opcode_t OP_SLTU  = 4'hF;

  // Bit positions inside the 4-bit condition vector {EQ,NE,GT,LT}.
  localparam int unsigned COND_EQ = 3;
  localparam int unsigned COND_NE = 2;
  localparam int unsigned COND_GT = 1;
  localparam int unsigned COND_LT = 0;

  // trap holds the op's trap enable; wen is resolved once at push time.
  typedef struct packed {
    opcode_t         op;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] res;
    logic            ovf;
    logic [3:0]      cond;
    logic            trap;
    logic            wen;
  } wb_entry_t;

  function automatic wb_entry_t make_entry(opcode_t op, logic [RA_W-1:0] rd,
                                           logic [XLEN-1:0] res, logic ovf,
                                           logic [3:0] cond, logic trap_en);
    wb_entry_t e;
    e.op   = op;
    e.rd   = rd;
    e.res  = res;
    e.ovf  = ovf;
    e.cond = cond;
    e.trap = trap_en;
    e.wen  = (rd != '0) & ~(ovf & trap_en);
    return e;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Bundle of all alu_writeback signals other than clock and reset.
//  in_*     : ALU result push channel (valid/ready)
//  rf_*     : register-file retire channel (valid/ready, write enable/address/data)
//  flags    : architectural {EQ,NE,GT,LT}
//  trap_*   : sticky overflow trap and its clear
//  fwd_*    : combinational bypass lookup
// master = ALU/register-file side, slave = the writeback stage.
interface alu_writeback_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  opcode_t         in_opcode;
  logic [RA_W-1:0] in_rd;
  logic [XLEN-1:0] in_result;
  logic            in_ovf;
  logic [3:0]      in_cond;
  logic            in_trap_en;

  logic            rf_valid;
  logic            rf_ready;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic [3:0]      flags;
  logic            trap_pending;
  logic            trap_clr;

  logic [RA_W-1:0] fwd_rs;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;

  modport master (
    output in_valid, in_opcode, in_rd, in_result, in_ovf, in_cond, in_trap_en,
    output rf_ready, trap_clr, fwd_rs,
    input  in_ready, rf_valid, rf_we, rf_waddr, rf_wdata, flags, trap_pending,
    input  fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_result, in_ovf, in_cond, in_trap_en,
    input  rf_ready, trap_clr, fwd_rs,
    output in_ready, rf_valid, rf_we, rf_waddr, rf_wdata, flags, trap_pending,
    output fwd_hit, fwd_data
  );

endinterface

// File: rtl/wb_queue.sv
// In-order FIFO of writeback entries. All storage slots are exposed together with the read
// pointer and occupancy so the parent can do an age-ordered bypass scan.
//  clk_i, rst_ni : clock, async active-low reset
//  push_i/pop_i  : enqueue entry_i / dequeue head (caller guarantees no overflow/underflow)
//  flush_i       : empty the queue; dominates push and pop
//  entries_o     : raw storage, rd_ptr_o : head slot, count_o : valid entries
module wb_queue
  import alu_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  wb_entry_t       entry_i,
  output wb_entry_t       entries_o [Depth],
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [CntW-1:0] count_o
);

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the wrap.
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: queues ALU results in order, retires them to the register-file write
// port, maintains the {EQ,NE,GT,LT} flags from retired SUBs, raises a sticky overflow trap and
// answers bypass queries from the queued (not yet retired) results.
//  clk   : clock, rising edge
//  rst_n : asynchronous active-low reset
//  bus   : alu_writeback_if.slave (push channel, retire channel, flags, trap, bypass)
// Datapath widths XLEN/RA_W come from alu_pkg.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_writeback_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t       q_entries [DEPTH];
  logic [PtrW-1:0] q_rd_ptr;
  logic [CntW-1:0] q_count;
  wb_entry_t       head;
  wb_entry_t       new_entry;

  logic       push, pop, head_traps;
  logic [3:0] flags_q, flags_d;
  logic       trap_q, trap_d;

  assign head       = q_entries[q_rd_ptr];
  assign head_traps = head.ovf & head.trap;
  assign new_entry  = make_entry(bus.in_opcode, bus.in_rd, bus.in_result, bus.in_ovf,
                                 bus.in_cond, bus.in_trap_en);

  assign bus.in_ready = (q_count != CntW'(DEPTH));
  assign bus.rf_valid = (q_count != '0) & ~trap_q;
  assign bus.rf_we    = bus.rf_valid & head.wen;
  assign bus.rf_waddr = head.rd;
  assign bus.rf_wdata = head.res;

  // Pushes during a pending trap are handshaken but discarded.
  assign push = bus.in_valid & bus.in_ready & ~trap_q;
  assign pop  = bus.rf_valid & bus.rf_ready;

  wb_queue #(
    .Depth (DEPTH)
  ) u_queue (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .flush_i   (trap_q),
    .entry_i   (new_entry),
    .entries_o (q_entries),
    .rd_ptr_o  (q_rd_ptr),
    .count_o   (q_count)
  );

  always_comb begin
    flags_d = flags_q;
    trap_d  = trap_q;
    if (bus.trap_clr) trap_d = 1'b0;
    if (pop) begin
      if (head_traps) begin
        trap_d = 1'b1;  // a new trap beats a simultaneous clear
      end else if (head.op == OP_SUB) begin
        flags_d = head.cond;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
      trap_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      trap_q  <= trap_d;
    end
  end

  assign bus.flags        = flags_q;
  assign bus.trap_pending = trap_q;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    logic [PtrW-1:0] idx;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    idx          = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = q_rd_ptr + PtrW'(i);
      if ((CntW'(i) < q_count) && q_entries[idx].wen && (q_entries[idx].rd == bus.fwd_rs)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = q_entries[idx].res;
      end
    end
    if (trap_q || (bus.fwd_rs == '0)) begin
      bus.fwd_hit  = 1'b0;
      bus.fwd_data = '0;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_writeback_if bus ();

  alu_writeback #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of pending ops plus the architectural state.
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ovf;
    logic [3:0]  cond;
    logic        ten;
  } m_ent_t;

  m_ent_t     mq[$];
  logic [3:0] m_flags;
  logic       m_trap;

  function automatic bit m_wen(m_ent_t e);
    return (e.rd != 5'd0) && !(e.ovf && e.ten);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] res, input logic ovf, input logic [3:0] cond,
                        input logic ten);
    bus.in_valid   = v;
    bus.in_opcode  = op;
    bus.in_rd      = rd;
    bus.in_result  = res;
    bus.in_ovf     = ovf;
    bus.in_cond    = cond;
    bus.in_trap_en = ten;
  endtask

  task automatic model_reset();
    mq.delete();
    m_flags = 4'b0000;
    m_trap  = 1'b0;
  endtask

  // Compare every output with the model, then advance model and DUT by one clock edge.
  task automatic step();
    m_ent_t     h, e;
    bit         exp_rdy, exp_rfv, pop, push, hit;
    logic [3:0] nf;
    logic       nt;
    logic [31:0] fd;
    #1;
    exp_rdy = (mq.size() != DEPTH);
    exp_rfv = (mq.size() != 0) && !m_trap;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("rf_valid", 32'(bus.rf_valid), 32'(exp_rfv));
    chk("flags", 32'(bus.flags), 32'(m_flags));
    chk("trap_pending", 32'(bus.trap_pending), 32'(m_trap));
    if (exp_rfv) begin
      h = mq[0];
      chk("rf_we", 32'(bus.rf_we), 32'(m_wen(h)));
      chk("rf_waddr", 32'(bus.rf_waddr), 32'(h.rd));
      chk("rf_wdata", bus.rf_wdata, h.res);
    end else begin
      chk("rf_we_idle", 32'(bus.rf_we), 32'd0);
    end
    hit = 1'b0;
    fd  = '0;
    if (!m_trap && bus.fwd_rs != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (m_wen(mq[i]) && mq[i].rd == bus.fwd_rs) begin
          hit = 1'b1;
          fd  = mq[i].res;
          break;
        end
      end
    end
    chk("fwd_hit", 32'(bus.fwd_hit), 32'(hit));
    if (hit) chk("fwd_data", bus.fwd_data, fd);

    nf   = m_flags;
    nt   = m_trap;
    pop  = exp_rfv && bus.rf_ready;
    push = bus.in_valid && exp_rdy && !m_trap;
    if (bus.trap_clr) nt = 1'b0;
    if (pop) begin
      h = mq.pop_front();
      if (h.ovf && h.ten) nt = 1'b1;
      else if (h.op == 4'h2) nf = h.cond;
    end
    if (m_trap) mq.delete();
    if (push) begin
      e.op = bus.in_opcode; e.rd = bus.in_rd; e.res = bus.in_result;
      e.ovf = bus.in_ovf; e.cond = bus.in_cond; e.ten = bus.in_trap_en;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    m_flags = nf;
    m_trap  = nt;
  endtask

  initial begin
    // 1: reset with in_valid held high
    rst_n = 1'b0;
    set_in(1'b1, OP_ADD, 5'd1, 32'h1, 1'b0, 4'h0, 1'b0);
    bus.rf_ready = 1'b1;
    bus.trap_clr = 1'b0;
    bus.fwd_rs   = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_rf_valid", 32'(bus.rf_valid), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_trap", 32'(bus.trap_pending), 32'd0);
    chk("rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    rst_n = 1'b1;

    // 2: SUB then ADD retire on consecutive cycles
    set_in(1'b1, OP_SUB, 5'd3, 32'h0, 1'b0, 4'b1000, 1'b0);
    step();
    chk("t2_v1", 32'(bus.rf_valid), 32'd1);
    chk("t2_we1", 32'(bus.rf_we), 32'd1);
    chk("t2_a1", 32'(bus.rf_waddr), 32'd3);
    chk("t2_d1", bus.rf_wdata, 32'h0);
    set_in(1'b1, OP_ADD, 5'd4, 32'h7, 1'b0, 4'b0100, 1'b0);
    step();
    chk("t2_flags1", 32'(bus.flags), 32'b1000);
    chk("t2_a2", 32'(bus.rf_waddr), 32'd4);
    chk("t2_d2", bus.rf_wdata, 32'h7);
    set_in(1'b0, OP_OUT, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0);
    step();
    chk("t2_flags2", 32'(bus.flags), 32'b1000);
    chk("t2_empty", 32'(bus.rf_valid), 32'd0);

    // 3: backpressure
    bus.rf_ready = 1'b0;
    set_in(1'b1, OP_OR, 5'd9, 32'h10, 1'b0, 4'h0, 1'b0);
    step();
    set_in(1'b1, OP_AND, 5'd10, 32'h20, 1'b0, 4'h0, 1'b0);
    step();
    chk("t3_full", 32'(bus.in_ready), 32'd0);
    set_in(1'b1, OP_XOR, 5'd11, 32'h30, 1'b0, 4'h0, 1'b0);
    step();
    chk("t3_still_full", 32'(bus.in_ready), 32'd0);
    chk("t3_head", 32'(bus.rf_waddr), 32'd9);
    bus.rf_ready = 1'b1;
    set_in(1'b0, OP_OUT, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0);
    step();
    chk("t3_ready_back", 32'(bus.in_ready), 32'd1);
    chk("t3_second", bus.rf_wdata, 32'h20);
    step();
    chk("t3_drained", 32'(bus.rf_valid), 32'd0);

    // 4: rd=0 never writes, never forwards
    bus.rf_ready = 1'b0;
    set_in(1'b1, OP_OUT, 5'd0, 32'hDEAD, 1'b0, 4'h0, 1'b0);
    step();
    set_in(1'b0, OP_OUT, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0);
    bus.fwd_rs = 5'd0;
    #1;
    chk("t4_valid", 32'(bus.rf_valid), 32'd1);
    chk("t4_we", 32'(bus.rf_we), 32'd0);
    chk("t4_fwd", 32'(bus.fwd_hit), 32'd0);
    bus.rf_ready = 1'b1;
    step();

    // 5: overflow trap, flush, dropped pushes, clear
    bus.rf_ready = 1'b0;
    set_in(1'b1, OP_ADD, 5'd5, 32'h55, 1'b1, 4'h0, 1'b1);
    step();
    set_in(1'b1, OP_OR, 5'd6, 32'h66, 1'b0, 4'h0, 1'b0);
    step();
    set_in(1'b0, OP_OUT, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0);
    bus.rf_ready = 1'b1;
    #1;
    chk("t5_no_we5", 32'(bus.rf_we), 32'd0);
    step();
    chk("t5_trap", 32'(bus.trap_pending), 32'd1);
    chk("t5_no_rfv", 32'(bus.rf_valid), 32'd0);
    set_in(1'b1, OP_MULT, 5'd8, 32'h88, 1'b0, 4'h0, 1'b0);
    step();
    set_in(1'b0, OP_OUT, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0);
    step();
    chk("t5_dropped", 32'(bus.rf_valid), 32'd0);
    chk("t5_ready", 32'(bus.in_ready), 32'd1);
    bus.trap_clr = 1'b1;
    step();
    bus.trap_clr = 1'b0;
    chk("t5_cleared", 32'(bus.trap_pending), 32'd0);
    chk("t5_flushed", 32'(bus.rf_valid), 32'd0);
    set_in(1'b1, OP_DIV, 5'd12, 32'hC, 1'b0, 4'h0, 1'b0);
    step();
    set_in(1'b0, OP_OUT, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0);
    chk("t5_resume_we", 32'(bus.rf_we), 32'd1);
    chk("t5_resume_a", 32'(bus.rf_waddr), 32'd12);
    step();

    // 6: bypass returns the youngest match, skipping a trapping entry
    for (int k = 0; k < 2; k++) begin
      bus.rf_ready = 1'b0;
      set_in(1'b1, OP_ADD, 5'd7, 32'h11, k[0], 4'h0, k[0]);
      step();
      set_in(1'b1, OP_ADD, 5'd7, 32'h22, 1'b0, 4'h0, 1'b0);
      step();
      set_in(1'b0, OP_OUT, 5'd0, 32'h0, 1'b0, 4'h0, 1'b0);
      bus.fwd_rs = 5'd7;
      #1;
      chk("t6_hit", 32'(bus.fwd_hit), 32'd1);
      chk("t6_data", bus.fwd_data, 32'h22);
      bus.rf_ready = 1'b1;
      repeat (3) step();
      bus.trap_clr = 1'b1;
      step();
      bus.trap_clr = 1'b0;
    end

    // Reset mid-operation discards queued entries
    bus.rf_ready = 1'b0;
    set_in(1'b1, OP_SUB, 5'd2, 32'h2, 1'b0, 4'b0010, 1'b0);
    step();
    set_in(1'b1, OP_SUB, 5'd3, 32'h3, 1'b0, 4'b0001, 1'b0);
    bus.rf_ready = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_rfv", 32'(bus.rf_valid), 32'd0);
    chk("mrst_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_flags", 32'(bus.flags), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      set_in(($urandom_range(9) < 7) ? 1'b1 : 1'b0,
             ($urandom_range(3) == 0) ? OP_SUB : 4'($urandom_range(15)),
             5'($urandom_range(7)), $urandom(),
             ($urandom_range(9) == 0) ? 1'b1 : 1'b0,
             4'($urandom_range(15)), 1'($urandom_range(1)));
      bus.rf_ready = ($urandom_range(9) < 6) ? 1'b1 : 1'b0;
      bus.trap_clr = ($urandom_range(5) == 0) ? 1'b1 : 1'b0;
      bus.fwd_rs   = 5'($urandom_range(7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
